// File: rtl/sq_gen.sv
// Square-wave generator: emits N falling edges spread evenly over a fixed window
// of WINDOW_CYCLES clocks, using a Bresenham-style accumulator stepped by 2N.
module sq_gen #(
  parameter int WINDOW_CYCLES = 480000,
  parameter int CNT_W         = 10
) (
  input  logic             int_osc,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] count_target,
  output logic             square,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edges_sent
);

  localparam int ACC_W = $clog2(WINDOW_CYCLES + (2 ** (CNT_W + 1)));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_timer;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_n;
  logic               r_square;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_edges;

  state_t             w_state_nxt;
  logic [ACC_W-1:0]   w_timer_nxt;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [CNT_W-1:0]   w_n_nxt;
  logic               w_square_nxt;
  logic [CNT_W-1:0]   w_edges_nxt;
  logic [ACC_W-1:0]   w_two_n;
  logic [ACC_W-1:0]   w_acc_sum;

  assign w_two_n   = {{(ACC_W-CNT_W-1){1'b0}}, r_n, 1'b0};
  assign w_acc_sum = r_acc + w_two_n;

  // Next-state and next-output logic; abort is checked before the end-of-window test
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_acc_nxt    = r_acc;
    w_n_nxt      = r_n;
    w_square_nxt = r_square;
    w_edges_nxt  = r_edges;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_n_nxt      = count_target;
          w_timer_nxt  = {ACC_W{1'b0}};
          w_acc_nxt    = {ACC_W{1'b0}};
          w_edges_nxt  = {CNT_W{1'b0}};
          w_square_nxt = 1'b1;
          w_state_nxt  = RUN;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      RUN: begin
        if (abort) begin
          w_square_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end else begin
          if (w_acc_sum >= ACC_W'(WINDOW_CYCLES)) begin
            w_acc_nxt    = w_acc_sum - ACC_W'(WINDOW_CYCLES);
            w_square_nxt = ~r_square;
            if (r_square) begin
              w_edges_nxt = r_edges + CNT_W'(1);
            end else begin
              w_edges_nxt = r_edges;
            end
          end else begin
            w_acc_nxt = w_acc_sum;
          end
          if (r_timer == ACC_W'(WINDOW_CYCLES - 1)) begin
            w_timer_nxt = {ACC_W{1'b0}};
            w_state_nxt = FINISH;
          end else begin
            w_timer_nxt = r_timer + ACC_W'(1);
          end
        end
      end
      FINISH: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_square_nxt = 1'b1;
      end
    endcase
  end

  // State and registered outputs; busy/done are derived from the next state so they track it exactly
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_timer  <= {ACC_W{1'b0}};
      r_acc    <= {ACC_W{1'b0}};
      r_n      <= {CNT_W{1'b0}};
      r_square <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_edges  <= {CNT_W{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_acc    <= w_acc_nxt;
      r_n      <= w_n_nxt;
      r_square <= w_square_nxt;
      r_busy   <= (w_state_nxt == RUN);
      r_done   <= (w_state_nxt == FINISH);
      r_edges  <= w_edges_nxt;
    end
  end

  assign square     = r_square;
  assign busy       = r_busy;
  assign done       = r_done;
  assign edges_sent = r_edges;

endmodule
